// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch PC register and IF/ID pipeline register with
//            stall, flush and redirect control. Defining FETCH_PERF_CNT_EN
//            adds the FetchCount / StallCount performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemRd,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    logic [31:0] r_pcf;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;

    logic [31:0] w_pc_plus4_f;
    logic [31:0] w_target;
    logic        w_pc_hold;
    logic        w_unused_target_lsbs;

    assign w_pc_plus4_f = r_pcf + c_PC_STEP;
    // Targets are word aligned; the low address bits are discarded.
    assign w_target             = {PCTargetE[31:2], 2'b00};
    assign w_unused_target_lsbs = &{1'b0, PCTargetE[1:0]};
    assign w_pc_hold            = StallF && !PCSrcE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pcf <= RESET_PC;
        end else if (PCSrcE) begin
            r_pcf <= w_target;
        end else if (!StallF) begin
            r_pcf <= w_pc_plus4_f;
        end
    end

    // A flush loads the all-zero bubble even while decode is stalled.
    always_ff @(posedge clk) begin
        if (!reset_n || FlushD) begin
            r_instr_d    <= 32'h0000_0000;
            r_pc_d       <= 32'h0000_0000;
            r_pc_plus4_d <= 32'h0000_0000;
            r_valid_d    <= 1'b0;
        end else if (!StallD) begin
            r_instr_d    <= ImemRd;
            r_pc_d       <= r_pcf;
            r_pc_plus4_d <= w_pc_plus4_f;
            r_valid_d    <= 1'b1;
        end
    end

    assign ImemAddr = r_pcf;
    assign PCF      = r_pcf;
    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PCPlus4D = r_pc_plus4_d;
    assign ValidD   = r_valid_d;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fetch_count <= 32'h0000_0000;
            r_stall_count <= 32'h0000_0000;
        end else if (w_pc_hold) begin
            r_stall_count <= r_stall_count + 32'd1;
        end else begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign FetchCount = r_fetch_count;
    assign StallCount = r_stall_count;
`else
    logic w_unused_hold;
    assign w_unused_hold = w_pc_hold;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL provide port StallF, input, 1, hold the PC.
REQ-005 SHALL provide port StallD, input, 1, hold the IF/ID register.
REQ-006 SHALL provide port FlushD, input, 1, clear the IF/ID register to a bubble.
REQ-007 SHALL provide port PCSrcE, input, 1, redirect the PC to PCTargetE (taken branch or jal).
REQ-008 SHALL provide port PCTargetE, input, 32, the redirect target.
REQ-009 SHALL provide port ImemAddr, output, 32, the instruction memory address.
REQ-010 SHALL provide port ImemRd, input, 32, the instruction word, read combinationally in the same cycle.
REQ-011 SHALL provide port PCF, output, 32, the current fetch PC.
REQ-012 SHALL provide port InstrD, output, 32, the instruction presented to decode.
REQ-013 SHALL provide port PCD, output, 32, the PC of InstrD.
REQ-014 SHALL provide port PCPlus4D, output, 32, PCD+4.
REQ-015 SHALL provide port ValidD, output, 1, high when InstrD is a real fetched instruction.

Function
REQ-016 SHALL drive ImemAddr = PCF combinationally.
REQ-017 SHALL compute PCPlus4F = PCF + 4 modulo 2^32; 32'hFFFFFFFC wraps to 32'h00000000.
REQ-018 SHALL load PCF <= {PCTargetE[31:2],2'b00} when PCSrcE=1, regardless of StallF; a redirect overrides a stall.
REQ-019 SHALL hold PCF when StallF=1 and PCSrcE=0, and otherwise load PCF <= PCPlus4F.
REQ-020 SHALL load the bubble (InstrD=32'h00000000, PCD=0, PCPlus4D=0, ValidD=0) when FlushD=1, regardless of StallD; a flush overrides a stall.
REQ-021 SHALL hold all IF/ID outputs when StallD=1 and FlushD=0.
REQ-022 SHALL otherwise load InstrD<=ImemRd, PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1.
REQ-023 SHALL produce a latency of one cycle from a PCF value to its instruction on InstrD.
REQ-024 SHALL place an all-zero instruction on InstrD for every bubble, so decode sees opcode 7'b0000000 (nop).

Reset
REQ-025 SHALL, on reset_n=0 at a rising edge, set PCF=RESET_PC, InstrD=0, PCD=0, PCPlus4D=0, ValidD=0, overriding all other inputs.
REQ-026 SHALL apply a reset asserted mid-stall or mid-redirect the same way; no pending redirect survives it.
REQ-027 SHALL begin fetch from RESET_PC on the first edge after reset_n returns high; ValidD rises one cycle later.

Configuration
REQ-028 SHALL, with macro FETCH_PERF_CNT_EN defined, add output FetchCount (32) and output StallCount (32).
REQ-029 SHALL, in that configuration, clear both counters on reset and let both wrap modulo 2^32.
REQ-030 SHALL, in that configuration, increment FetchCount on each edge where PCF advances or redirects.
REQ-031 SHALL, in that configuration, increment StallCount on each edge where StallF=1 and PCSrcE=0.
REQ-032 SHALL, without FETCH_PERF_CNT_EN, omit both ports and all counter logic, with no other behavioural difference.

Verification
REQ-033 Reset with RESET_PC=32'h00000100, ImemRd tracking address -> PCF=0x100, 0x104, 0x108; InstrD lags PCF by one cycle; ValidD=1 from the second cycle.
REQ-034 StallF=StallD=1 for 3 cycles at PCF=0x108 -> PCF and InstrD frozen; StallCount=3 if enabled; fetch resumes at 0x10C.
REQ-035 PCSrcE=1, PCTargetE=0x203, FlushD=1, StallF=1 in one cycle -> next PCF=0x200; InstrD=0; ValidD=0.
REQ-036 FlushD=1 and StallD=1 together -> bubble loaded, not hold.
REQ-037 PCF=0xFFFFFFFC, no stall -> next PCF=0x00000000; PCPlus4D=0x00000000 on the following cycle.
REQ-038 reset_n=0 during a 2-cycle stall with PCSrcE=1 -> PCF=RESET_PC and all IF/ID outputs and counters zero on the next edge.
